// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle shared by the round-robin arbiter and its requesters.
// The requester side (master) drives enable and requests; the arbiter
// (slave) returns the registered grant, owner index, valid and timeout pulse.
interface rr_arbiter_4_if;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output en, req,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  en, req,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a hold limit. The owner keeps the grant
// while it requests, for at most MAX_HOLD consecutive cycles when others wait.
// All outputs are registered; there is no combinational path from req to gnt.
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter_4_if.slave  bus
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // First asserted request in the order last+1, last+2, last+3, last.
   function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] last);
      pick_t      res;
      logic [1:0] idx;
      res = '0;
      // Walk from lowest to highest priority so the last hit is the winner.
      for (int i = 4; i >= 1; i--) begin
         idx = last + i[1:0];
         if (r[idx]) begin
            res.found = 1'b1;
            res.idx   = idx;
         end
      end
      return res;
   endfunction

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    gnt_idx_q, gnt_idx_d;   // doubles as the priority pointer
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
   logic          gnt_valid_q, gnt_valid_d;

   pick_t win_all;
   pick_t win_other;

   // Candidate winners: among all requests, and excluding the current owner.
   assign win_all   = rr_pick(bus.req, gnt_idx_q);
   assign win_other = rr_pick(bus.req & ~gnt_q, gnt_idx_q);

   // Next-state and next-output logic for the IDLE/BUSY machine.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (bus.en && win_all.found) begin
               state_d   = BUSY;
               gnt_d     = 4'b0001 << win_all.idx;
               gnt_idx_d = win_all.idx;
               cnt_d     = '0;
            end
         end

         BUSY: begin
            if (!bus.en) begin
               // Enable wins over release and timeout; pointer is kept.
               state_d = IDLE;
               gnt_d   = '0;
            end else if (!bus.req[gnt_idx_q]) begin
               // Voluntary release: hand over on the same edge if possible.
               if (win_all.found) begin
                  gnt_d     = 4'b0001 << win_all.idx;
                  gnt_idx_d = win_all.idx;
                  cnt_d     = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (cnt_q == HOLD_LAST) begin
               // Hold limit reached: force a handover if anyone else waits.
               timeout_d = 1'b1;
               cnt_d     = '0;
               if (win_other.found) begin
                  gnt_d     = 4'b0001 << win_other.idx;
                  gnt_idx_d = win_other.idx;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase

      gnt_valid_d = (state_d == BUSY);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the arbiter holds only a few control flops, so all of them are
      // reset; pointer starts at 3 so the first search begins at requester 0.
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= 2'd3;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
         gnt_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rr_arbiter_4_if bus ();

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Structural invariant sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt_valid_eq_or", {31'd0, bus.gnt_valid}, {31'd0, |bus.gnt});
         check("gnt_onehot_decode",
               {31'd0, (bus.gnt == 4'b0000) || (bus.gnt == (4'b0001 << bus.gnt_idx))},
               32'd1);
      end
   end

   // ---------------- reference model ----------------
   // Owner/last pointer, whether a grant is active, and how many consecutive
   // cycles the current owner has held it.
   bit m_valid;
   int m_owner;
   int m_held;
   bit m_to;

   function automatic int model_pick(input logic [3:0] r, input int last);
      for (int off = 1; off <= 4; off++) begin
         int k;
         k = (last + off) % 4;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_owner = 3;
      m_held  = 0;
      m_to    = 0;
   endtask

   task automatic model_grant(input int w);
      m_valid = 1;
      m_owner = w;
      m_held  = 1;
   endtask

   task automatic model_edge(input logic en, input logic [3:0] r);
      logic [3:0] others;
      m_to = 0;
      if (!m_valid) begin
         if (en && r != 0) model_grant(model_pick(r, m_owner));
      end else if (!en) begin
         m_valid = 0;
      end else if (!r[m_owner]) begin
         if (r != 0) model_grant(model_pick(r, m_owner));
         else        m_valid = 0;
      end else if (m_held == MAX_HOLD) begin
         m_to   = 1;
         others = r & ~(4'b0001 << m_owner);
         if (others != 0) model_grant(model_pick(others, m_owner));
         else             m_held = 1;
      end else begin
         m_held++;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".gnt"},       {28'd0, bus.gnt},
            m_valid ? (32'd1 << m_owner) : 32'd0);
      check({tag, ".gnt_idx"},   {30'd0, bus.gnt_idx},   m_owner);
      check({tag, ".gnt_valid"}, {31'd0, bus.gnt_valid}, {31'd0, m_valid});
      check({tag, ".timeout"},   {31'd0, bus.timeout},   {31'd0, m_to});
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset.gnt",       {28'd0, bus.gnt},       32'h0);
      check("reset.gnt_idx",   {30'd0, bus.gnt_idx},   32'd3);
      check("reset.gnt_valid", {31'd0, bus.gnt_valid}, 32'd0);
      check("reset.timeout",   {31'd0, bus.timeout},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Apply inputs, advance one edge, update the model; outputs settle at +1.
   task automatic cycle(input logic en, input logic [3:0] r);
      bus.en  = en;
      bus.req = r;
      @(posedge clk);
      model_edge(en, r);
      #1;
   endtask

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       to;
   } vec_t;

   vec_t vecs[10];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "time limit");
   end

   initial begin : main
      // Directed vectors: expected outputs after the edge that sampled inputs.
      vecs[0] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 4'b1011, 4'b0000, 2'd3, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].en, vecs[i].req);
         check($sformatf("vec%0d.gnt", i),       {28'd0, bus.gnt},       {28'd0, vecs[i].gnt});
         check($sformatf("vec%0d.gnt_idx", i),   {30'd0, bus.gnt_idx},   {30'd0, vecs[i].idx});
         check($sformatf("vec%0d.gnt_valid", i), {31'd0, bus.gnt_valid}, {31'd0, vecs[i].valid});
         check($sformatf("vec%0d.timeout", i),   {31'd0, bus.timeout},   {31'd0, vecs[i].to});
      end

      // All four requesting: rotate 0,1,2,3,0 with MAX_HOLD cycles each.
      do_reset();
      for (int c = 1; c <= 4 * MAX_HOLD + 1; c++) begin
         cycle(1'b1, 4'b1111);
         check($sformatf("rot%0d.gnt_idx", c), {30'd0, bus.gnt_idx}, ((c - 1) / MAX_HOLD) % 4);
         check($sformatf("rot%0d.gnt_valid", c), {31'd0, bus.gnt_valid}, 32'd1);
         check($sformatf("rot%0d.timeout", c), {31'd0, bus.timeout},
               {31'd0, (c > 1) && ((c - 1) % MAX_HOLD == 0)});
      end

      // Sole requester holds through repeated hold-limit expiries.
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         cycle(1'b1, 4'b0100);
         check($sformatf("solo%0d.gnt", c), {28'd0, bus.gnt}, 32'h4);
         check($sformatf("solo%0d.timeout", c), {31'd0, bus.timeout},
               {31'd0, (c == 9) || (c == 17)});
      end

      // Asynchronous reset in the middle of a grant.
      do_reset();
      cycle(1'b1, 4'b0010);
      check("async.pre_gnt", {28'd0, bus.gnt}, 32'h2);
      #1;
      rst_n = 1'b0;
      #1;
      check("async.gnt",       {28'd0, bus.gnt},       32'h0);
      check("async.gnt_valid", {31'd0, bus.gnt_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 4'b0110);
      check("async.after_gnt", {28'd0, bus.gnt}, 32'h2);

      // Randomized traffic against the reference model.
      do_reset();
      begin
         logic [3:0] r;
         logic       e;
         r = 4'b0000;
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 15) != 0);
            cycle(e, r);
            check_model($sformatf("rnd%0d", c));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-way resource among 4 requesters.
- Emits a 2-bit owner index plus a one-hot grant vector. The one-hot vector is exactly the 2-to-4 decode of the index, so either form may drive select lines downstream.
- Grant is held while the owner keeps requesting, capped by a hold timeout so no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant. Legal range 2..256.

Ports:
- clk        input   1  system clock, rising edge.
- rst_n      input   1  asynchronous active-low reset.
- en         input   1  arbiter enable. Low blocks new grants and drops any current grant.
- req        input   4  request per requester, level-sensitive.
- gnt        output  4  one-hot grant, registered. All-zero when idle.
- gnt_idx    output  2  binary index of the owner, registered. Holds the last owner when idle.
- gnt_valid  output  1  high when any gnt bit is high. Equals |gnt.
- timeout    output  1  one-cycle pulse on the cycle after a forced release by the hold limit.

Behaviour:
- One clock domain is used: clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n low; release is synchronous to clk.
- Reset values:
  - gnt=4'b0000, gnt_idx=2'd3, gnt_valid=0, timeout=0.
  - Internal priority pointer last=3, so the first search starts at requester 0.
  - Hold counter cnt=0. State=IDLE.
- States: IDLE, BUSY.
- Search order from pointer last: last+1, last+2, last+3, last, all mod 4 (wrap-around 3 -> 0). The first asserted req in that order wins.
- Latency: a request sampled at edge N appears on gnt/gnt_idx after edge N, i.e. 1 cycle. There is no combinational path from req to gnt.
- IDLE:
  - If en=1 and req!=0: pick a winner, set gnt=1<<winner, gnt_idx=winner, last=winner, cnt=0, go to BUSY.
  - Otherwise stay in IDLE with gnt=0.
- BUSY, evaluated every edge in this priority order:
  1. en=0: gnt=0, go to IDLE. last and gnt_idx are kept. No timeout pulse.
  2. req[gnt_idx]=0 (voluntary release):
     - If other requests are pending, grant the next winner on this same edge, with no dead cycle; cnt=0.
     - Otherwise gnt=0 and go to IDLE.
  3. req[gnt_idx]=1 and cnt==MAX_HOLD-1 (forced release):
     - timeout=1 for one cycle.
     - If any other req bit is set, grant the next winner from last, excluding the current owner.
     - If only the current owner is requesting, re-grant the same owner with cnt=0.
  4. Otherwise: cnt=cnt+1 and the grant is unchanged.
- An owner therefore holds gnt for at most MAX_HOLD consecutive cycles whenever a competitor is waiting.
- Counter width is clog2(MAX_HOLD). It must never wrap while holding.
- gnt is always zero or one-hot, never multi-hot. gnt_valid=1 exactly when the state is BUSY.
- Simultaneous events:
  - en falling on the same edge as a release or timeout: the en=0 rule wins.
  - A new request arriving on the same edge as a release: it takes part in that edge's search.
- Reset mid-grant: gnt drops asynchronously the moment rst_n goes low. After release the arbiter restarts from requester 0.
- Requests from non-owners are never latched. A req pulse that drops before it is sampled while eligible is lost.

Test Plan:
- Reset, then en=1, req=4'b0100 -> one cycle later gnt=4'b0100, gnt_idx=2, gnt_valid=1. Drop req -> gnt=0 after the next edge.
- req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0; each owner gets exactly 8 cycles; timeout pulses once at each handover; no idle cycles between owners.
- Owner 1 drops req while req=4'b1001 -> gnt moves to 4'b1000 on the same edge as the release (round robin from 1 gives 3 before 0); cnt restarts.
- Only req[2] held for 20 cycles, MAX_HOLD=8 -> gnt stays 4'b0100 throughout; timeout pulses at cycles 9 and 17; gnt never drops.
- en=0 while owner 3 holds with req=4'b1011 -> gnt=0 after the next edge, gnt_idx stays 3. Set en=1 again -> grant goes to requester 0.
- Assert rst_n=0 mid-grant (gnt=4'b0010) -> gnt=0 and gnt_valid=0 immediately, with no clock edge. After release with req=4'b0110 -> gnt=4'b0010.
- Throughout all scenarios, an assertion checks that gnt is zero or one-hot and that gnt==(1<<gnt_idx) whenever gnt_valid=1.
